// File: rtl/puf_crp_pkg.sv
// Shared definitions for the arbiter-PUF challenge/response driver.
//   - state_t    : driver FSM states
//   - LFSR_TAPS  : feedback taps of the 12-bit challenge LFSR (bits 11,10,9,3)
//   - *_DEF      : default CHAL_W, RESP_BITS, SETTLE_CYCLES
//   - cnt_w()    : counter width able to hold 0..n-1 (at least 1 bit)
package puf_crp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LAUNCH,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [11:0] LFSR_TAPS = 12'hE08;

  localparam int CHAL_W_DEF        = 12;
  localparam int RESP_BITS_DEF     = 16;
  localparam int SETTLE_CYCLES_DEF = 4;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/puf_lfsr12.sv
// 12-bit Fibonacci LFSR producing PUF challenges.
// Ports:
//   clk, clr  : clock, asynchronous active-high reset (state returns to SEED)
//   load      : write load_val into the register (zero is replaced by 1)
//   load_val  : value to load
//   step      : advance one shift-left step
//   q         : current LFSR state
module puf_lfsr12
  import puf_crp_pkg::*;
#(
  parameter logic [11:0] SEED = 12'h001
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        load,
  input  logic [11:0] load_val,
  input  logic        step,
  output logic [11:0] q
);

  logic [11:0] q_q;
  logic [11:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      // The all-zero state would lock the LFSR, so it is never loaded.
      q_d = (load_val == 12'h000) ? 12'h001 : load_val;
    end else if (step) begin
      q_d = {q_q[10:0], ^(q_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) q_q <= SEED;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/puf_crp_driver.sv
// Challenge-response driver for one feed-forward arbiter PUF level.
// Each response bit runs IDLE/ARM -> LAUNCH -> SETTLE -> SAMPLE; RESP_BITS bits
// are packed MSB-first into resp and offered to the host with valid/ready.
// Ports:
//   clk, clr          : clock, asynchronous active-high reset
//   start             : request one response word (IDLE only)
//   seed_load, seed   : reload the challenge LFSR (IDLE only, beats start)
//   C                 : challenge bus, equals the LFSR state
//   puf_clr, launch   : PUF line clear / race launch
//   r                 : arbiter output, asynchronous to clk
//   resp, resp_valid  : collected word and its valid flag
//   resp_ready        : host accepts resp
//   busy              : high in every state except IDLE
module puf_crp_driver
  import puf_crp_pkg::*;
#(
  parameter int                CHAL_W        = CHAL_W_DEF,
  parameter int                RESP_BITS     = RESP_BITS_DEF,
  parameter int                SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter logic [CHAL_W-1:0] LFSR_SEED     = 12'h001
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 seed_load,
  input  logic [CHAL_W-1:0]    seed,
  output logic [CHAL_W-1:0]    C,
  output logic                 puf_clr,
  output logic                 launch,
  input  logic                 r,
  output logic [RESP_BITS-1:0] resp,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 busy
);

  localparam int BIT_CNT_W = cnt_w(RESP_BITS);
  localparam int SETTLE_W  = cnt_w(SETTLE_CYCLES);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST    = BIT_CNT_W'(RESP_BITS - 1);
  localparam logic [SETTLE_W-1:0]  SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t                 state_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [SETTLE_W-1:0]    settle_q;
  logic [RESP_BITS-1:0]   resp_q;
  logic                   resp_valid_q;
  logic                   puf_clr_q;
  logic                   launch_q;
  logic                   busy_q;
  logic [11:0]            lfsr_q;

  (* ASYNC_REG = "TRUE" *) logic r_meta_q;
  (* ASYNC_REG = "TRUE" *) logic r_sync_q;

  logic lfsr_load;
  logic lfsr_step;

  assign lfsr_load = (state_q == IDLE) && seed_load;
  assign lfsr_step = (state_q == SAMPLE);

  puf_lfsr12 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .clr      (clr),
    .load     (lfsr_load),
    .load_val (seed),
    .step     (lfsr_step),
    .q        (lfsr_q)
  );

  // r is asynchronous: two flops before it is used
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_meta_q <= 1'b0;
      r_sync_q <= 1'b0;
    end else begin
      r_meta_q <= r;
      r_sync_q <= r_meta_q;
    end
  end

  // FSM with registered outputs: each output takes the value of the state being entered
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      settle_q     <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
      puf_clr_q    <= 1'b1;
      launch_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // seed_load wins; the LFSR load itself happens in u_lfsr
          if (!seed_load && start) begin
            bit_cnt_q <= '0;
            resp_q    <= '0;
            busy_q    <= 1'b1;
            state_q   <= ARM;
          end
        end
        ARM: begin
          puf_clr_q <= 1'b0;
          launch_q  <= 1'b1;
          state_q   <= LAUNCH;
        end
        LAUNCH: begin
          settle_q <= SETTLE_LOAD;
          state_q  <= SETTLE;
        end
        SETTLE: begin
          if (settle_q == '0) state_q  <= SAMPLE;
          else                settle_q <= settle_q - SETTLE_W'(1);
        end
        SAMPLE: begin
          resp_q    <= {resp_q[RESP_BITS-2:0], r_sync_q};
          bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
          puf_clr_q <= 1'b1;
          launch_q  <= 1'b0;
          if (bit_cnt_q == BIT_LAST) begin
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            state_q <= ARM;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign C          = lfsr_q;
  assign puf_clr    = puf_clr_q;
  assign launch     = launch_q;
  assign resp       = resp_q;
  assign resp_valid = resp_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_puf_crp_driver.sv
module tb_puf_crp_driver;

  logic        clk;
  logic        clr;
  logic        start, seed_load, r, resp_ready;
  logic [11:0] seed;
  logic [11:0] c1;
  logic        puf_clr, launch, resp_valid, busy;
  logic [15:0] resp;

  logic        start2, seed_load2, resp_ready2;
  logic [11:0] seed2;
  logic [11:0] c2;
  logic        puf_clr2, launch2, resp_valid2, busy2, r2;
  logic [7:0]  resp2;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  exp2_q[$];

  logic [11:0] chal[0:31];
  int          runlen[0:31];
  int          nruns;
  bit          wave_ok, c_stable_ok;

  puf_crp_driver u_dut (
    .clk(clk), .clr(clr), .start(start), .seed_load(seed_load), .seed(seed),
    .C(c1), .puf_clr(puf_clr), .launch(launch), .r(r), .resp(resp),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .busy(busy)
  );

  // r follows the challenge LSB directly, exercising the synchronizer delay
  assign r2 = c2[0];

  puf_crp_driver #(.RESP_BITS(8), .SETTLE_CYCLES(2)) u_dut2 (
    .clk(clk), .clr(clr), .start(start2), .seed_load(seed_load2), .seed(seed2),
    .C(c2), .puf_clr(puf_clr2), .launch(launch2), .r(r2), .resp(resp2),
    .resp_valid(resp_valid2), .resp_ready(resp_ready2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] lstep(input logic [11:0] x);
    return {x[10:0], x[11] ^ x[10] ^ x[9] ^ x[3]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start, follow one word to resp_valid, record per-bit waveform data.
  task automatic run_word(input string tag, output int lat);
    bit          in_run;
    int          run;
    logic [15:0] e;
    in_run = 0; run = 0; nruns = 0; wave_ok = 1; c_stable_ok = 1; lat = -1;
    @(negedge clk); start = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (puf_clr !== ~launch) wave_ok = 0;
      if (launch) begin
        if (!in_run) begin
          in_run = 1; run = 1;
          if (nruns < 32) chal[nruns] = c1;
        end else begin
          run++;
          if (nruns < 32 && c1 !== chal[nruns]) c_stable_ok = 0;
        end
      end else if (in_run) begin
        in_run = 0;
        if (nruns < 32) runlen[nruns] = run;
        nruns++;
      end
      if (resp_valid) begin
        lat = i - 1;
        break;
      end
    end
    if (lat < 0) check({tag, " valid_timeout"}, resp_valid, 1);
    else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, " resp"}, resp, e);
    end
  endtask

  initial begin
    int          lat;
    logic [11:0] x;
    logic [7:0]  w8;
    logic [15:0] held_resp;
    logic [11:0] held_c;
    bit          hold_ok;

    clr = 1'b1; start = 0; seed_load = 0; seed = '0; r = 0; resp_ready = 1;
    start2 = 0; seed_load2 = 0; seed2 = '0; resp_ready2 = 1;
    repeat (2) @(negedge clk);

    // reset state
    check("rst C", c1, 12'h001);
    check("rst puf_clr", puf_clr, 1);
    check("rst launch", launch, 0);
    check("rst resp", resp, 0);
    check("rst resp_valid", resp_valid, 0);
    check("rst busy", busy, 0);
    check("rst2 launch/puf_clr", {launch2, puf_clr2}, 2'b01);
    clr = 1'b0;
    @(negedge clk);

    // r tied high: all-ones word after 112 edges, single-cycle valid
    r = 1'b1;
    exp_q.push_back(16'hFFFF);
    run_word("ones", lat);
    check("ones latency", lat, 112);
    @(negedge clk);
    check("ones valid_drop", resp_valid, 0);
    check("ones busy_drop", busy, 0);

    // seed_load with start in the same cycle: seed wins, start dropped
    @(negedge clk); seed = 12'h800; seed_load = 1; start = 1;
    @(negedge clk); seed_load = 0; start = 0;
    check("seed800 C", c1, 12'h800);
    check("seed800 start_dropped", busy, 0);
    r = 1'b0;
    exp_q.push_back(16'h0000);
    run_word("seed800", lat);
    check("seed800 C_bit0", chal[0], 12'h800);
    check("seed800 C_bit1", chal[1], 12'h001);
    x = 12'h800;
    for (int k = 0; k < 16; k++) x = lstep(x);
    check("seed800 C_after16", c1, x);
    check("seed800 C_stable", c_stable_ok, 1);
    @(negedge clk);

    // r = C[0] on the SETTLE_CYCLES=2 instance
    x = 12'h001; w8 = '0;
    for (int k = 0; k < 8; k++) begin
      w8 = {w8[6:0], x[0]};
      x  = lstep(x);
    end
    exp2_q.push_back(w8);
    @(negedge clk); start2 = 1'b1;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 1) start2 = 1'b0;
      if (resp_valid2) begin lat = i - 1; break; end
    end
    if (lat < 0) check("rC0 valid_timeout", resp_valid2, 1);
    else begin
      check("rC0 latency", lat, 40);
      check("rC0 resp", resp2, exp2_q.pop_front());
      check("rC0 C_after8", c2, x);
    end
    @(negedge clk);
    check("rC0 busy_drop", busy2, 0);

    // host stalls for 30 cycles in DONE
    r = 1'b1; resp_ready = 1'b0;
    exp_q.push_back(16'hFFFF);
    run_word("stall", lat);
    held_resp = resp; held_c = c1; hold_ok = 1;
    for (int i = 0; i < 30; i++) begin
      start = (i % 3 == 0); seed_load = (i % 5 == 1); seed = 12'h5A5;
      @(negedge clk);
      if (!(resp_valid === 1'b1 && resp === held_resp && c1 === held_c && busy === 1'b1)) hold_ok = 0;
    end
    start = 0; seed_load = 0;
    check("stall valid", resp_valid, 1);
    check("stall resp", resp, held_resp);
    check("stall C", c1, held_c);
    check("stall hold_all", hold_ok, 1);
    resp_ready = 1'b1;
    @(negedge clk);
    check("stall valid_drop", resp_valid, 0);

    // clr during SETTLE of bit 5
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (38) @(negedge clk);
    check("clr pre launch", launch, 1);
    check("clr pre busy", busy, 1);
    clr = 1'b1;
    #1;
    check("clr C", c1, 12'h001);
    check("clr launch", launch, 0);
    check("clr puf_clr", puf_clr, 1);
    check("clr busy", busy, 0);
    check("clr resp", resp, 0);
    check("clr valid", resp_valid, 0);
    @(negedge clk); clr = 1'b0;
    @(negedge clk);
    exp_q.push_back(16'hFFFF);
    run_word("postclr", lat);
    check("postclr latency", lat, 112);
    check("postclr C_bit0", chal[0], 12'h001);
    @(negedge clk);

    // zero seed loads as 1; per-bit launch/puf_clr waveform
    @(negedge clk); seed = 12'h000; seed_load = 1;
    @(negedge clk); seed_load = 0;
    check("seed0 C", c1, 12'h001);
    r = 1'b0;
    exp_q.push_back(16'h0000);
    run_word("seed0", lat);
    check("seed0 runs", nruns, 16);
    for (int k = 0; k < 16; k++) check($sformatf("seed0 launch_len%0d", k), runlen[k], 6);
    check("seed0 puf_clr_vs_launch", wave_ok, 1);
    check("seed0 C_stable", c_stable_ok, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_crp_driver.md
# puf_crp_driver

Challenge-response driver for one feed-forward arbiter PUF level. It generates 12-bit challenges from an internal LFSR and drives them onto the level's challenge bus. For each challenge it clears the PUF lines, launches the race, waits a settle window, then samples the arbiter bit. It packs RESP_BITS sampled bits into one response word and hands that word to the host over a valid/ready handshake.

## Interface
- CHAL_W, 12: challenge width; must match the PUF level's C bus.
- RESP_BITS, 16: response bits collected per request, range 2..32.
- SETTLE_CYCLES, 4: cycles between launch and sample; minimum 2, which covers the r synchronizer.
- LFSR_SEED, 12'h001: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- clr  in  1  asynchronous, active-high reset.
- start  in  1  request one response word; honoured only in IDLE.
- seed_load  in  1  load seed into the LFSR; honoured only in IDLE; takes priority over start.
- seed  in  CHAL_W  new LFSR value; 0 is loaded as 12'h001.
- C  out  CHAL_W  challenge to the PUF level; always equals the LFSR state.
- puf_clr  out  1  clear to the PUF lines.
- launch  out  1  race launch to the PUF lines (the level's clk input).
- r  in  1  arbiter response; asynchronous to clk.
- resp  out  RESP_BITS  collected response word.
- resp_valid  out  1  resp holds a complete word.
- resp_ready  in  1  host accepts resp.
- busy  out  1  high in every state except IDLE.

## Operation
- Each bit is collected in a fixed sequence, IDLE → ARM → LAUNCH → SETTLE → SAMPLE, then back to ARM for the next bit or on to DONE after the last.
- IDLE: puf_clr=1, launch=0. seed_load=1 writes the LFSR. Otherwise start=1 clears bit_cnt and resp, then moves to ARM.
- ARM (1 cycle): puf_clr=1, launch=0, C stable.
- LAUNCH (1 cycle): puf_clr=0, launch=1. The settle counter loads SETTLE_CYCLES-1.
- SETTLE (SETTLE_CYCLES cycles): launch stays 1. Counts down to 0.
- SAMPLE (1 cycle): launch=1.
  - resp <= {resp[RESP_BITS-2:0], r_sync}; the first bit ends up in the MSB.
  - The LFSR advances one step.
  - bit_cnt increments. At RESP_BITS-1 the next state is DONE, otherwise ARM.
- DONE: resp_valid=1 and resp is held stable; puf_clr=1, launch=0. When resp_valid and resp_ready are both high, the transfer completes and the next state is IDLE.
- r is passed through a 2-flop synchronizer to produce r_sync. It is sampled only in SAMPLE.
- LFSR: Fibonacci, shifts left, lfsr <= {lfsr[10:0], lfsr[11]^lfsr[10]^lfsr[9]^lfsr[3]}. This is maximal length (4095 states), and the all-zero state is unreachable.
- start while busy is ignored, as is seed_load while busy. There is no abort other than clr.

## Timing
- Reset values:
  - state=IDLE, C=LFSR_SEED, puf_clr=1, launch=0.
  - resp=0, resp_valid=0, busy=0, bit_cnt=0, r_sync=0.
- clr mid-operation: all reset values apply immediately. The partial word is discarded. After clr falls the LFSR restarts at LFSR_SEED.
- Cost per bit: SETTLE_CYCLES+3 cycles. With defaults that is 7 cycles per bit.
- Latency: with start sampled at edge 0, the first ARM cycle begins at edge 0. resp_valid rises at edge RESP_BITS*(SETTLE_CYCLES+3), which is 112 with defaults.
- C changes only at the edge ending SAMPLE. It is therefore stable for the whole ARM..SAMPLE window of every bit.
- resp_ready=1 already present when DONE is entered: the transfer happens in DONE's first cycle. resp_valid is high for exactly 1 cycle, and start is accepted on the following IDLE cycle.
- seed_load and start in the same IDLE cycle: the seed loads and start is dropped.

## Structure
- Package puf_crp_pkg holds:
  - the state enum (IDLE, ARM, LAUNCH, SETTLE, SAMPLE, DONE);
  - the LFSR tap constant (bits 11, 10, 9, 3);
  - default CHAL_W, RESP_BITS and SETTLE_CYCLES;
  - the bit_cnt and settle-counter widths, computed with $clog2.
- Sub-module puf_lfsr12: ports clk, clr, load, load_val, step, q. It substitutes 1 when a zero seed is loaded.
- The synchronizer, FSM, counters and shift register stay in puf_crp_driver.
- Mark the synchronizer flops as asynchronous-register cells (ASYNC_REG).

## Test plan
- r tied 1, start pulsed once, resp_ready=1 → resp_valid rises at edge 112 with resp=16'hFFFF, then busy falls.
- seed_load with seed=12'h800, then start → C=12'h800 during bit 0 and C=12'h001 during bit 1. After 16 bits C equals 16 steps of the LFSR from 12'h800.
- r model returns C[0] → resp MSB-first equals C[0] of each challenge in sequence. Checks the 2-flop delay with SETTLE_CYCLES=2.
- resp_ready held 0 for 30 cycles in DONE → resp_valid stays 1 and resp is stable. start and seed_load pulses are ignored, and C is unchanged.
- clr pulsed during SETTLE of bit 5 → all outputs take their reset values asynchronously, C=LFSR_SEED. A new start runs a full 112-cycle request.
- seed_load with seed=0 → C=12'h001. Per-bit launch/puf_clr waveform checks: launch high for exactly SETTLE_CYCLES+2 cycles, and puf_clr low during exactly those cycles.
